// File: rtl/fma_pkg.sv
// Shared configuration, constants and helpers for the FMA accumulator alignment shifter.
package fma_pkg;

    typedef struct packed {
        int lanes;
        int acc_w;
        int sft_w;
    } alnsft_cfg_t;

    localparam alnsft_cfg_t ALNSFT_CFG_DEF = '{lanes: 4, acc_w: 48, sft_w: 6};

    // Coarse shift granule; the low 3 sft bits select the fine shift.
    localparam int COARSE   = 8;
    localparam int MASK_MAX = 128;

    // Mask of the low 'sft' bit positions (capped at 'width'): the bits a right shift discards.
    function automatic logic [MASK_MAX-1:0] sticky_mask(input logic [31:0] sft, input logic [31:0] width);
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_MAX; i++) begin
            m[i] = (32'(i) < sft) && (32'(i) < width);
        end
        return m;
    endfunction

endpackage

// File: rtl/fma_alnsft_lane.sv
// One lane of the alignment shifter: coarse shift into S1, fine shift and sticky merge into S2.
module fma_alnsft_lane
    import fma_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int SFT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cap1,
    input  logic               cap2,
    input  logic [ACC_W-1:0]   acc,
    input  logic [SFT_W-1:0]   sft,
    input  logic               en,
    output logic [ACC_W:0]     aln
);

    localparam int ALN_W = ACC_W + 1;

    logic [ALN_W-1:0] ext;
    logic [31:0]      crs_amt;
    logic [ALN_W-1:0] crs;
    logic             crs_st;

    logic [ALN_W-1:0] s1_crs;
    logic             s1_st;
    logic [2:0]       s1_fin;
    logic             s1_en;

    logic [31:0]      fin_amt;
    logic [ALN_W-1:0] fin;
    logic             fin_st;

    always_comb begin
        ext     = {acc, 1'b0};
        crs_amt = 32'(sft[SFT_W-1:3]) * 32'(COARSE);
        crs     = ext >> crs_amt;
        crs_st  = |(ext & ALN_W'(sticky_mask(crs_amt, 32'(ALN_W))));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_crs <= '0;
            s1_st  <= 1'b0;
            s1_fin <= '0;
            s1_en  <= 1'b0;
        end else if (cap1) begin
            s1_crs <= crs;
            s1_st  <= crs_st;
            s1_fin <= sft[2:0];
            s1_en  <= en;
        end
    end

    always_comb begin
        fin_amt = 32'(s1_fin);
        fin     = s1_crs >> fin_amt;
        fin_st  = s1_st | (|(s1_crs & ALN_W'(sticky_mask(fin_amt, 32'(ALN_W)))));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aln <= '0;
        end else if (cap2) begin
            aln <= s1_en ? {fin[ALN_W-1:1], fin[0] | fin_st} : '0;
        end
    end

endmodule

// File: rtl/fma_alnsft_pipe.sv
// N-lane accumulator alignment shifter: owns the accumulators, the two-stage valid/ready pipe and the lanes.
module fma_alnsft_pipe
    import fma_pkg::*;
#(
    parameter int LANES = ALNSFT_CFG_DEF.lanes,
    parameter int ACC_W = ALNSFT_CFG_DEF.acc_w,
    parameter int SFT_W = ALNSFT_CFG_DEF.sft_w
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LANES-1:0]           acc_we,
    input  logic [LANES*ACC_W-1:0]     acc_wdata,
    output logic [LANES*ACC_W-1:0]     acc_o,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES-1:0]           lane_en,
    input  logic [LANES*SFT_W-1:0]     sft,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*(ACC_W+1)-1:0] aln,
    output logic [LANES-1:0]           out_lane
);

    localparam int ALN_W = ACC_W + 1;

    logic [LANES*ACC_W-1:0] acc_q;
    logic                   s1_valid;
    logic [LANES-1:0]       s1_lane;
    logic                   s1_load;
    logic                   s2_load;
    logic                   accept;
    logic                   cap2;

    always_comb begin
        s2_load  = !out_valid || out_ready;
        s1_load  = s2_load || !s1_valid;
        in_ready = s1_load;
        accept   = in_valid && in_ready;
        cap2     = s2_load && s1_valid;
    end

    assign acc_o = acc_q;

    // The snapshot taken on accept reads acc_q, so a same-cycle write is seen only by later requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (acc_we[i]) acc_q[i*ACC_W +: ACC_W] <= acc_wdata[i*ACC_W +: ACC_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_lane   <= '0;
            out_valid <= 1'b0;
            out_lane  <= '0;
        end else begin
            if (s1_load) s1_valid  <= in_valid;
            if (accept)  s1_lane   <= lane_en;
            if (s2_load) out_valid <= s1_valid;
            if (cap2)    out_lane  <= s1_lane;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fma_alnsft_lane #(
            .ACC_W (ACC_W),
            .SFT_W (SFT_W)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .cap1  (accept),
            .cap2  (cap2),
            .acc   (acc_q[g*ACC_W +: ACC_W]),
            .sft   (sft[g*SFT_W +: SFT_W]),
            .en    (lane_en[g]),
            .aln   (aln[g*ALN_W +: ALN_W])
        );
    end

endmodule
